fifo_flags: RTL and testbench
=============================

// Module: fifo_flags
// PURPOSE
//  Parametrised synchronous FIFO, successor to the basic FIFO block: same storage
//  and handshake, plus selectable first-word-fall-through (FWFT) read mode,
//  almost-full/almost-empty thresholds, flush, and sticky overflow/underflow flags.
//  Any DEPTH up to 2**ADDR_W, including non-powers of two.
//  Used between producer/consumer blocks in one clock domain that need early back-pressure.
// PARAMETERS
//  ADDR_W    5   address width; DEPTH <= 2**ADDR_W
//  DATA_W    8   data width
//  DEPTH     32  storage words, >= 2
//  FWFT      0   0 = standard (registered read, 1-cycle latency); 1 = fall-through
//  AF_THRESH 28  almost_full when used >= AF_THRESH (1..DEPTH)
//  AE_THRESH 4   almost_empty when used <= AE_THRESH (0..DEPTH-1)
// PORTS
//  clk          in   1         clock, all logic on rising edge
//  rst          in   1         synchronous reset, active high
//  flush        in   1         synchronous empty; data discarded
//  err_clr      in   1         clears overflow/underflow
//  we           in   1         write enable
//  re           in   1         read enable
//  datai        in   DATA_W    write data
//  datao        out  DATA_W    read data
//  full         out  1         used == DEPTH
//  avail        out  1         data readable (see BEHAVIOUR)
//  empty        out  1         used == 0
//  almost_full  out  1         used >= AF_THRESH
//  almost_empty out  1         used <= AE_THRESH
//  overflow     out  1         sticky: write attempted while full, not accepted
//  underflow    out  1         sticky: read attempted while empty, not accepted
//  used         out  ADDR_W+1  words stored, 0..DEPTH
// BEHAVIOUR
//  Reset (rst=1 at edge): pointers=0, used=0, empty=1, full=0, avail=0,
//   almost_empty=1, almost_full=0, overflow=0, underflow=0, datao=0.
//  Priority per edge: rst > flush > we/re. Flush: pointers=0, used=0, datao unchanged;
//   sticky flags kept. we/re ignored that cycle.
//  wr_ok = we & (!full | rd_ok); rd_ok = re & !empty. Both may occur in one cycle.
//   Full + we&re: both accepted, used unchanged. Empty + we&re: write only, underflow set.
//  we & !wr_ok -> overflow=1 next edge; re & !rd_ok -> underflow=1 next edge.
//   Both hold until err_clr or rst. err_clr and a new error in one cycle: flag stays 1.
//  Pointers increment on accept and wrap DEPTH-1 -> 0 (explicit compare, not bit overflow).
//  used += wr_ok - rd_ok. All status outputs registered and consistent with used
//   after the same edge.
//  FWFT=0: on rd_ok at edge N, head word lands in datao at edge N; datao holds until the
//   next rd_ok. avail = !empty.
//  FWFT=1: datao always shows the head word while avail=1; rd_ok pops it and datao shows
//   the next word after that edge. A word written to an empty FIFO at edge N gives
//   avail=1 and valid datao after edge N (no extra cycle). avail = !empty.
//   datao don't-care when empty.
//  Never overwrite stored data; never change used on a rejected operation.
// STRUCTURE
//  Shared include fifo_defs.vh: FIFO_MODE_STD=0 and FIFO_MODE_FWFT=1 constants.
//   Elaboration-time check: DEPTH <= 2**ADDR_W and threshold ranges.
//  Sub-module fifo_dpram (DATA_W x DEPTH): 1 write port, 1 read port.
//   Synchronous write; read address-driven, so FWFT needs no extra latency.
//  Pointer/count/flag logic and the output register sit in fifo_flags.
// TESTING (bench uses DEPTH=5, ADDR_W=3, AF_THRESH=4, AE_THRESH=1 unless noted)
//  1 Reset: rst=1 for 2 cycles with we=1 -> used=0, empty=1, avail=0, datao=0,
//    almost_empty=1, flags=0.
//  2 Fill/wrap: write 0x11..0x15 -> full=1, almost_full after 4th; 6th write 0xAA
//    -> overflow=1, used=5. Read 5 -> 0x11..0x15 in order.
//    Repeat 3 times to cross pointer wrap at 4->0.
//  3 Simultaneous: at used=5, we=re=1 with 0x77 -> used=5, full=1, no overflow.
//    At used=0, we=re=1 -> used=1, underflow=1.
//  4 FWFT=1: write 0x3C into empty FIFO -> next cycle avail=1, datao=0x3C before any re.
//    re=1 -> empty=1 next edge.
//  5 Flush: used=3 plus a pending overflow, flush=1 with we=1 -> used=0, empty=1,
//    write dropped, overflow still 1. err_clr -> overflow=0.
//  6 Reset mid-operation: rst=1 while used=4 and we=re=1 -> all reset values next edge.
//    Prior data never read back.

Source files
------------

// File: rtl/fifo_flags_pkg.sv
// Shared definitions for the fifo_flags FIFO: read-mode encodings and the sticky error record.
package fifo_flags_pkg;

    // Read-mode selectors for the FWFT parameter.
    localparam int unsigned FIFO_MODE_STD  = 0;
    localparam int unsigned FIFO_MODE_FWFT = 1;

    // Sticky error flags, held until err_clr or reset.
    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

    // True when a mode value is one of the supported encodings.
    function automatic logic fifo_mode_valid(input int unsigned mode);
        return (mode == FIFO_MODE_STD) || (mode == FIFO_MODE_FWFT);
    endfunction

endpackage

// File: rtl/fifo_flags_dpram.sv
// Simple dual-port storage: synchronous write, address-driven (combinational) read so the
// fall-through mode sees the head word without an extra cycle.
module fifo_dpram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Storage write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fifo_flags.sv
// Synchronous FIFO with standard or fall-through read, almost-full/empty thresholds, flush and
// sticky overflow/underflow flags. Depth need not be a power of two.
module fifo_flags
    import fifo_flags_pkg::*;
#(
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned FWFT      = FIFO_MODE_STD,
    parameter int unsigned AF_THRESH = 28,
    parameter int unsigned AE_THRESH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              err_clr,
    input  logic              we,
    input  logic              re,
    input  logic [DATA_W-1:0] datai,
    output logic [DATA_W-1:0] datao,
    output logic              full,
    output logic              avail,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow,
    output logic [ADDR_W:0]   used
);

    typedef logic [ADDR_W-1:0] ptr_t;
    typedef logic [ADDR_W:0]   cnt_t;

    // Elaboration-time parameter sanity checks.
    if (DEPTH < 2 || DEPTH > (2 ** ADDR_W)) begin : g_chk_depth
        $error("fifo_flags: DEPTH must be in 2..2**ADDR_W");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_chk_af
        $error("fifo_flags: AF_THRESH must be in 1..DEPTH");
    end
    if (AE_THRESH > DEPTH - 1) begin : g_chk_ae
        $error("fifo_flags: AE_THRESH must be in 0..DEPTH-1");
    end
    if (!fifo_mode_valid(FWFT)) begin : g_chk_mode
        $error("fifo_flags: FWFT must be FIFO_MODE_STD or FIFO_MODE_FWFT");
    end

    // Wrap by explicit compare so non-power-of-two depths work.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    ptr_t              wr_ptr_q, wr_ptr_d;
    ptr_t              rd_ptr_q, rd_ptr_d;
    cnt_t              used_q, used_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              af_q, af_d;
    logic              ae_q, ae_d;
    fifo_err_t         err_q, err_d;
    logic [DATA_W-1:0] datao_q, datao_d;
    logic [DATA_W-1:0] ram_rdata;
    logic              rd_ok, wr_ok;

    // A read frees a slot in the same cycle, so a full FIFO can still accept a write alongside it.
    assign rd_ok = re & ~empty_q;
    assign wr_ok = we & (~full_q | rd_ok);

    fifo_dpram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_ok & ~flush & ~rst),
        .wr_addr (wr_ptr_q),
        .wr_data (datai),
        .rd_addr (rd_ptr_q),
        .rd_data (ram_rdata)
    );

    // Next-state for pointers, occupancy, status flags, sticky errors and the read register.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        used_d   = used_q;
        datao_d  = datao_q;

        err_d.overflow  = err_q.overflow & ~err_clr;
        err_d.underflow = err_q.underflow & ~err_clr;

        if (flush) begin
            // Flush empties the FIFO but keeps the last read word and any sticky errors.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            used_d   = '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (rd_ok) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
                datao_d  = ram_rdata;
            end
            case ({wr_ok, rd_ok})
                2'b10:   used_d = used_q + cnt_t'(1);
                2'b01:   used_d = used_q - cnt_t'(1);
                default: used_d = used_q;
            endcase
            // A new error wins over err_clr in the same cycle.
            if (we && !wr_ok) begin
                err_d.overflow = 1'b1;
            end
            if (re && !rd_ok) begin
                err_d.underflow = 1'b1;
            end
        end

        empty_d = (used_d == '0);
        full_d  = (used_d == cnt_t'(DEPTH));
        af_d    = (used_d >= cnt_t'(AF_THRESH));
        ae_d    = (used_d <= cnt_t'(AE_THRESH));
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            used_q   <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            err_q    <= '0;
            datao_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            used_q   <= used_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            err_q    <= err_d;
            datao_q  <= datao_d;
        end
    end

    // Fall-through mode shows the head word directly; zero when nothing is stored.
    assign datao = (FWFT == FIFO_MODE_FWFT) ? (empty_q ? '0 : ram_rdata) : datao_q;

    assign used         = used_q;
    assign empty        = empty_q;
    assign avail        = ~empty_q;
    assign full         = full_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign overflow     = err_q.overflow;
    assign underflow    = err_q.underflow;

endmodule

// File: tb/tb_fifo_flags.sv
// Directed plus random bench for fifo_flags: one standard and one fall-through instance share
// stimulus and are compared against a queue-based model.
module tb_fifo_flags;

    localparam int unsigned DEPTH = 5;
    localparam int unsigned AF    = 4;
    localparam int unsigned AE    = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0, flush = 1'b0, err_clr = 1'b0, we = 1'b0, re = 1'b0;
    logic [7:0] datai = '0;

    logic [7:0] datao_s, datao_f;
    logic       full_s, avail_s, empty_s, af_s, ae_s, ovf_s, udf_s;
    logic       full_f, avail_f, empty_f, af_f, ae_f, ovf_f, udf_f;
    logic [3:0] used_s, used_f;

    always #5 clk = ~clk;

    fifo_flags #(
        .ADDR_W (3), .DATA_W (8), .DEPTH (DEPTH), .FWFT (0), .AF_THRESH (AF), .AE_THRESH (AE)
    ) u_std (
        .clk (clk), .rst (rst), .flush (flush), .err_clr (err_clr), .we (we), .re (re),
        .datai (datai), .datao (datao_s), .full (full_s), .avail (avail_s), .empty (empty_s),
        .almost_full (af_s), .almost_empty (ae_s), .overflow (ovf_s), .underflow (udf_s),
        .used (used_s)
    );

    fifo_flags #(
        .ADDR_W (3), .DATA_W (8), .DEPTH (DEPTH), .FWFT (1), .AF_THRESH (AF), .AE_THRESH (AE)
    ) u_fwft (
        .clk (clk), .rst (rst), .flush (flush), .err_clr (err_clr), .we (we), .re (re),
        .datai (datai), .datao (datao_f), .full (full_f), .avail (avail_f), .empty (empty_f),
        .almost_full (af_f), .almost_empty (ae_f), .overflow (ovf_f), .underflow (udf_f),
        .used (used_f)
    );

    // Reference model state.
    logic [7:0] mq [$];
    logic       m_ovf = 1'b0, m_udf = 1'b0;
    logic [7:0] m_dout = '0;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Apply one edge of the FIFO rules to the model.
    task automatic model_edge();
        bit rd, wr;
        if (rst) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
            m_dout = '0;
        end else if (flush) begin
            mq.delete();
            m_ovf = m_ovf & ~err_clr;
            m_udf = m_udf & ~err_clr;
        end else begin
            rd = re && (mq.size() > 0);
            wr = we && ((mq.size() < DEPTH) || rd);
            m_ovf = (m_ovf & ~err_clr) | (we & ~wr);
            m_udf = (m_udf & ~err_clr) | (re & ~rd);
            if (rd) m_dout = mq.pop_front();
            if (wr) mq.push_back(datai);
        end
    endtask

    task automatic check_all();
        int n;
        n = mq.size();
        chk("used", 32'(used_s), n);
        chk("empty", 32'(empty_s), 32'(n == 0));
        chk("avail", 32'(avail_s), 32'(n != 0));
        chk("full", 32'(full_s), 32'(n == DEPTH));
        chk("almost_full", 32'(af_s), 32'(n >= AF));
        chk("almost_empty", 32'(ae_s), 32'(n <= AE));
        chk("overflow", 32'(ovf_s), 32'(m_ovf));
        chk("underflow", 32'(udf_s), 32'(m_udf));
        chk("datao_std", 32'(datao_s), 32'(m_dout));
        chk("fwft_used", 32'(used_f), n);
        chk("fwft_avail", 32'(avail_f), 32'(n != 0));
        chk("fwft_flags", {30'd0, ovf_f, udf_f}, {30'd0, m_ovf, m_udf});
        if (n != 0) chk("datao_fwft", 32'(datao_f), 32'(mq[0]));
    endtask

    task automatic step(input logic w, input logic r, input logic f, input logic ec,
                        input logic rs, input logic [7:0] d);
        @(negedge clk);
        we = w; re = r; flush = f; err_clr = ec; rst = rs; datai = d;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        logic [7:0] v;

        // Reset held two cycles with a write request present.
        step(1, 0, 0, 0, 1, 8'h99);
        step(1, 0, 0, 0, 1, 8'h99);
        chk("rst_used", 32'(used_s), 0);
        chk("rst_empty", 32'(empty_s), 1);
        chk("rst_datao", 32'(datao_s), 0);
        chk("rst_ae", 32'(ae_s), 1);

        // Fill, overflow, drain; three rounds so pointers cross the 4->0 wrap.
        for (int round = 0; round < 3; round++) begin
            for (int i = 0; i < 5; i++) begin
                v = 8'h11 + 8'(i);
                step(1, 0, 0, 0, 0, v);
                if (i == 3) chk("af_after_4th", 32'(af_s), 1);
            end
            chk("fill_full", 32'(full_s), 1);
            step(1, 0, 0, 0, 0, 8'hAA);
            chk("ovf_set", 32'(ovf_s), 1);
            chk("ovf_used", 32'(used_s), 5);
            step(0, 0, 0, 1, 0, 8'h00);
            for (int i = 0; i < 5; i++) begin
                step(0, 1, 0, 0, 0, 8'h00);
                v = 8'h11 + 8'(i);
                chk("drain_order", 32'(datao_s), 32'(v));
            end
        end

        // Simultaneous read/write at full, then at empty.
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 8'h40 + 8'(i));
        step(1, 1, 0, 0, 0, 8'h77);
        chk("sim_full_used", 32'(used_s), 5);
        chk("sim_full_noovf", 32'(ovf_s), 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 8'h00);
        step(1, 1, 0, 0, 0, 8'h5A);
        chk("sim_empty_used", 32'(used_s), 1);
        chk("sim_empty_udf", 32'(udf_s), 1);
        step(0, 1, 0, 1, 0, 8'h00);

        // Fall-through: write to empty, data visible before any read.
        step(1, 0, 0, 0, 0, 8'h3C);
        chk("fwft_avail_now", 32'(avail_f), 1);
        chk("fwft_datao_now", 32'(datao_f), 32'h3C);
        step(0, 1, 0, 0, 0, 8'h00);
        chk("fwft_empty_after", 32'(empty_f), 1);

        // Flush with pending overflow and a concurrent write.
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 8'h60 + 8'(i));
        step(0, 1, 0, 0, 0, 8'h00);
        step(0, 1, 0, 0, 0, 8'h00);
        chk("pre_flush_used", 32'(used_s), 3);
        step(1, 0, 1, 0, 0, 8'hEE);
        chk("flush_used", 32'(used_s), 0);
        chk("flush_ovf_kept", 32'(ovf_s), 1);
        chk("flush_datao_kept", 32'(datao_s), 32'h61);
        step(0, 0, 0, 1, 0, 8'h00);
        chk("errclr_ovf", 32'(ovf_s), 0);

        // Reset mid-operation; old data must not reappear.
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 8'hC0 + 8'(i));
        step(1, 1, 0, 0, 1, 8'hDD);
        chk("midrst_used", 32'(used_s), 0);
        chk("midrst_datao", 32'(datao_s), 0);
        step(0, 1, 0, 0, 0, 8'h00);
        chk("midrst_udf", 32'(udf_s), 1);
        chk("midrst_datao2", 32'(datao_s), 0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
                 1'($urandom_range(0, 99) < 3), 1'($urandom_range(0, 99) < 10),
                 1'($urandom_range(0, 99) < 2), 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
